// File: rtl/mlt_pkg.sv
// Shared widths, FSM encoding and the round-robin grant helper for the
// two-requester multiplier arbiter.
package mlt_pkg;

  localparam int A_W       = 16;
  localparam int B_W       = 8;
  localparam int Y_W       = 24;
  localparam int MLT_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
    logic g;
    if (req0 && req1) begin
      g = ~last;
    end else if (req1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/mlt.sv
// Unsigned 16x8 shift-add multiplier: one start pulse, eight add/shift steps,
// busy high while stepping, full 24-bit product held on y_bo afterwards.
module mlt
  import mlt_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [A_W-1:0] a_bi,
  input  logic [B_W-1:0] b_bi,
  output logic           busy_o,
  output logic [Y_W-1:0] y_bo
);

  localparam logic [3:0] LAST_STEP = 4'(MLT_STEPS - 1);

  logic [Y_W-1:0] mcand_r;
  logic [Y_W-1:0] acc_r;
  logic [B_W-1:0] mplier_r;
  logic [3:0]     cnt_r;
  logic           busy_r;

  // Operand load on start, then one conditional add and shift per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_r  <= {Y_W{1'b0}};
      acc_r    <= {Y_W{1'b0}};
      mplier_r <= {B_W{1'b0}};
      cnt_r    <= 4'd0;
      busy_r   <= 1'b0;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + 4'd1;
      if (cnt_r == LAST_STEP) begin
        busy_r <= 1'b0;
      end
    end else if (start_i) begin
      mcand_r  <= {{(Y_W - A_W){1'b0}}, a_bi};
      mplier_r <= b_bi;
      acc_r    <= {Y_W{1'b0}};
      cnt_r    <= 4'd0;
      busy_r   <= 1'b1;
    end
  end

  assign busy_o = busy_r;
  assign y_bo   = acc_r;

endmodule

// File: rtl/mlt_arb.sv
// Round-robin arbiter that shares one mlt instance between two requesters and
// returns each product with a one-cycle done pulse.
module mlt_arb
  import mlt_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req0_i,
  input  logic [A_W-1:0] a0_bi,
  input  logic [B_W-1:0] b0_bi,
  output logic           busy0_o,
  output logic           done0_o,
  output logic [Y_W-1:0] y0_bo,
  input  logic           req1_i,
  input  logic [A_W-1:0] a1_bi,
  input  logic [B_W-1:0] b1_bi,
  output logic           busy1_o,
  output logic           done1_o,
  output logic [Y_W-1:0] y1_bo
);

  state_t         state_r, state_s;
  logic           start_r, start_s;
  logic           gnt_r, gnt_s;
  logic           last_r, last_s;
  logic [A_W-1:0] a_r, a_s;
  logic [B_W-1:0] b_r, b_s;
  logic           busy0_r, busy0_s, busy1_r, busy1_s;
  logic           done0_r, done0_s, done1_r, done1_s;
  logic [Y_W-1:0] y0_r, y0_s, y1_r, y1_s;
  logic           mlt_busy_s;
  logic [Y_W-1:0] mlt_y_s;

  mlt u_mlt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_r),
    .a_bi   (a_r),
    .b_bi   (b_r),
    .busy_o (mlt_busy_s),
    .y_bo   (mlt_y_s)
  );

  // Next-state and next-output logic; only the granted side's outputs move.
  always_comb begin
    state_s = state_r;
    start_s = start_r;
    gnt_s   = gnt_r;
    last_s  = last_r;
    a_s     = a_r;
    b_s     = b_r;
    busy0_s = busy0_r;
    busy1_s = busy1_r;
    done0_s = 1'b0;
    done1_s = 1'b0;
    y0_s    = y0_r;
    y1_s    = y1_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          gnt_s = pick_grant(req0_i, req1_i, last_r);
          if (gnt_s) begin
            a_s     = a1_bi;
            b_s     = b1_bi;
            busy1_s = 1'b1;
          end else begin
            a_s     = a0_bi;
            b_s     = b0_bi;
            busy0_s = 1'b1;
          end
          start_s = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        start_s = 1'b0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mlt_busy_s) begin
          if (gnt_r) begin
            y1_s    = mlt_y_s;
            done1_s = 1'b1;
            busy1_s = 1'b0;
          end else begin
            y0_s    = mlt_y_s;
            done0_s = 1'b1;
            busy0_s = 1'b0;
          end
          last_s  = gnt_r;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        start_s = 1'b0;
        busy0_s = 1'b0;
        busy1_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      start_r <= 1'b0;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      a_r     <= {A_W{1'b0}};
      b_r     <= {B_W{1'b0}};
      busy0_r <= 1'b0;
      busy1_r <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      y0_r    <= {Y_W{1'b0}};
      y1_r    <= {Y_W{1'b0}};
    end else begin
      state_r <= state_s;
      start_r <= start_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      a_r     <= a_s;
      b_r     <= b_s;
      busy0_r <= busy0_s;
      busy1_r <= busy1_s;
      done0_r <= done0_s;
      done1_r <= done1_s;
      y0_r    <= y0_s;
      y1_r    <= y1_s;
    end
  end

  assign busy0_o = busy0_r;
  assign busy1_o = busy1_r;
  assign done0_o = done0_r;
  assign done1_o = done1_r;
  assign y0_bo   = y0_r;
  assign y1_bo   = y1_r;

endmodule

// File: tb/tb_mlt_arb.sv
// Self-checking bench for mlt_arb: scoreboard of expected products, a cycle
// monitor for latency/exclusivity/hold rules, and directed corner sequences.
module tb_mlt_arb;
  import mlt_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        req0, req1;
  logic [15:0] a0, a1;
  logic [7:0]  b0, b1;
  logic        busy0, busy1, done0, done1;
  logic [23:0] y0, y1;

  mlt_arb dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .req0_i (req0),
    .a0_bi  (a0),
    .b0_bi  (b0),
    .busy0_o(busy0),
    .done0_o(done0),
    .y0_bo  (y0),
    .req1_i (req1),
    .a1_bi  (a1),
    .b1_bi  (b1),
    .busy1_o(busy1),
    .done1_o(done1),
    .y1_bo  (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] y;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          dcnt[2];
  bit          test_done = 1'b0;
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  int          order_q[$];
  int          dcyc_q[$];

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", nm, act, exp);
    end
  endtask

  task automatic sb_compare(input int p, input logic [23:0] act);
    logic [23:0] e;
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_done%0d: got y=0x%06h, expected no done", p, act);
    end else begin
      if (p == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("sb_y%0d", p), act, e);
    end
  endtask

  task automatic monitor();
    logic        rst_edge;
    logic [1:0]  b, d, bprev, dprev;
    logic [23:0] y[2];
    logic [23:0] yprev[2];
    int          rise[2];
    bprev = 2'b00; dprev = 2'b00; yprev[0] = 24'd0; yprev[1] = 24'd0;
    rise[0] = 0; rise[1] = 0;
    while (!test_done) begin
      @(posedge clk);
      rst_edge = rst_i;
      cyc++;
      @(negedge clk);
      b = {busy1, busy0};
      d = {done1, done0};
      y[0] = y0;
      y[1] = y1;
      if (!rst_edge) begin
        for (int p = 0; p < 2; p++) begin
          if (b[p] && !bprev[p]) rise[p] = cyc;
          if (d[p]) begin
            check($sformatf("latency%0d", p), 24'(cyc - rise[p]), 24'(MLT_STEPS + 2));
            check($sformatf("done_pulse%0d", p), 24'(dprev[p]), 24'd0);
            sb_compare(p, y[p]);
            dcnt[p]++;
            order_q.push_back(p);
            dcyc_q.push_back(cyc);
          end else begin
            check($sformatf("y%0d_hold", p), y[p], yprev[p]);
          end
        end
        if (|d) check("done_excl", 24'(d[0] & d[1]), 24'd0);
        if (|b) check("busy_excl", 24'(b[0] & b[1]), 24'd0);
      end
      bprev = b;
      dprev = d;
      yprev = y;
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic [15:0] a, input logic [7:0] b);
    if (p == 0) begin
      req0 = r; a0 = a; b0 = b;
    end else begin
      req1 = r; a1 = a; b1 = b;
    end
  endtask

  task automatic wait_total(input int target, input int budget, input string nm);
    int n = 0;
    while ((dcnt[0] + dcnt[1]) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(nm, 24'(dcnt[0] + dcnt[1]), 24'(target));
  endtask

  task automatic wait_busy(input int p, input int budget, input string nm);
    int n = 0;
    while (((p == 0) ? busy0 : busy1) !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(nm, 24'((p == 0) ? busy0 : busy1), 24'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy0"}, 24'(busy0), 24'd0);
    check({nm, "_busy1"}, 24'(busy1), 24'd0);
    check({nm, "_done0"}, 24'(done0), 24'd0);
    check({nm, "_done1"}, 24'(done1), 24'd0);
    check({nm, "_y0"}, y0, 24'd0);
    check({nm, "_y1"}, y1, 24'd0);
  endtask

  task automatic run_main();
    vec_t        vecs[7];
    int          tot;
    logic [23:0] other;

    vecs[0] = '{0, 16'h0003, 8'h05, 24'h00000F};
    vecs[1] = '{1, 16'hFFFF, 8'hFF, 24'hFEFF01};
    vecs[2] = '{0, 16'h1234, 8'h00, 24'h000000};
    vecs[3] = '{1, 16'h0000, 8'hFF, 24'h000000};
    vecs[4] = '{0, 16'hFFFF, 8'h01, 24'h00FFFF};
    vecs[5] = '{1, 16'h0001, 8'hFF, 24'h0000FF};
    vecs[6] = '{0, 16'h8001, 8'h80, 24'h400080};

    rst_i = 1'b1;
    set_req(0, 1'b0, 16'h0000, 8'h00);
    set_req(1, 1'b0, 16'h0000, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    check_all_zero("reset");

    // Tie right after reset: 0 first, then strict alternation while both hold.
    exp_q0.push_back(24'd14);   exp_q1.push_back(24'h001000);
    exp_q0.push_back(24'd14);   exp_q1.push_back(24'h001000);
    set_req(0, 1'b1, 16'h0002, 8'h07);
    set_req(1, 1'b1, 16'h0100, 8'h10);
    wait_total(4, 60, "tie_dones");
    set_req(0, 1'b0, 16'h0002, 8'h07);
    set_req(1, 1'b0, 16'h0100, 8'h10);
    if (order_q.size() == 4 && dcyc_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 24'(order_q[i]), 24'(i % 2));
      for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), 24'(dcyc_q[i] - dcyc_q[i-1]), 24'(MLT_STEPS + 3));
    end else begin
      check("rr_count", 24'(order_q.size()), 24'd4);
    end
    order_q.delete();
    dcyc_q.delete();

    // Single operations from the table.
    for (int i = 0; i < 7; i++) begin
      tot = dcnt[0] + dcnt[1];
      other = (vecs[i].r == 0) ? y1 : y0;
      if (vecs[i].r == 0) exp_q0.push_back(vecs[i].y);
      else                exp_q1.push_back(vecs[i].y);
      set_req(vecs[i].r, 1'b1, vecs[i].a, vecs[i].b);
      wait_busy(vecs[i].r, 4, $sformatf("vec%0d_busy", i));
      set_req(vecs[i].r, 1'b0, vecs[i].a, vecs[i].b);
      wait_total(tot + 1, 20, $sformatf("vec%0d_done", i));
      check($sformatf("vec%0d_y", i), (vecs[i].r == 0) ? y0 : y1, vecs[i].y);
      check($sformatf("vec%0d_other_y", i), (vecs[i].r == 0) ? y1 : y0, other);
    end

    // Held request: second grant on the first IDLE edge after done.
    tot = dcnt[0] + dcnt[1];
    exp_q0.push_back(24'd30);
    exp_q0.push_back(24'd30);
    set_req(0, 1'b1, 16'h0005, 8'h06);
    wait_total(tot + 1, 20, "held_done1");
    check("held_gap_busy0", 24'(busy0), 24'd0);
    @(negedge clk);
    #1;
    check("held_regrant_busy0", 24'(busy0), 24'd1);
    wait_total(tot + 2, 20, "held_done2");
    set_req(0, 1'b0, 16'h0005, 8'h06);

    // Reset five cycles after a grant aborts with no done pulse.
    tot = dcnt[0] + dcnt[1];
    set_req(0, 1'b1, 16'h0007, 8'h07);
    wait_busy(0, 4, "abort_busy");
    set_req(0, 1'b0, 16'h0007, 8'h07);
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("abort");
    rst_i = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_done", 24'(dcnt[0] + dcnt[1]), 24'(tot));
    exp_q0.push_back(24'd81);
    set_req(0, 1'b1, 16'h0009, 8'h09);
    wait_busy(0, 4, "post_abort_busy");
    set_req(0, 1'b0, 16'h0009, 8'h09);
    wait_total(tot + 1, 20, "post_abort_done");
    check("post_abort_y0", y0, 24'd81);

    // Toggling req1 while busy1 must not create an extra grant.
    tot = dcnt[1];
    exp_q1.push_back(24'h002034);
    set_req(1, 1'b1, 16'h0ABC, 8'h03);
    wait_busy(1, 4, "ign_busy");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      req1 = ~req1;
    end
    req1 = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("ign_single_done", 24'(dcnt[1]), 24'(tot + 1));
    check("ign_y1", y1, 24'h002034);

    check("sb_empty0", 24'(exp_q0.size()), 24'd0);
    check("sb_empty1", 24'(exp_q1.size()), 24'd0);
    test_done = 1'b1;
  endtask

  initial begin
    dcnt[0] = 0;
    dcnt[1] = 0;
    fork
      monitor();
      run_main();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
